// File: rtl/l2_line_responder_if.sv
// Line-transfer bus between one L1, the L2 responder and main memory.
// The slave modport is the L2 itself; master is its environment (L1 plus memory).
interface l2_line_responder_if;
   logic         l1_read;
   logic         l1_write;
   logic [29:0]  l1_addr;
   logic [127:0] l1_wdata;
   logic [127:0] l1_rdata;
   logic         l1_ready;
   logic         mem_read;
   logic         mem_write;
   logic [27:0]  mem_addr;
   logic [127:0] mem_wdata;
   logic [127:0] mem_rdata;
   logic         mem_ready;

   modport slave (
      input  l1_read, l1_write, l1_addr, l1_wdata, mem_rdata, mem_ready,
      output l1_rdata, l1_ready, mem_read, mem_write, mem_addr, mem_wdata
   );

   modport master (
      output l1_read, l1_write, l1_addr, l1_wdata, mem_rdata, mem_ready,
      input  l1_rdata, l1_ready, mem_read, mem_write, mem_addr, mem_wdata
   );
endinterface

// File: rtl/l2_line_responder.sv
// Direct-mapped write-back L2 answering L1 line requests, with fills and
// write-backs to main memory. All outputs are registered.
module l2_line_responder #(
   parameter int unsigned SET_BITS   = 3,
   parameter int unsigned NUM_OF_SET = 2 ** SET_BITS,
   parameter int unsigned TAG_W      = 28 - SET_BITS
) (
   input logic                clk,
   input logic                proc_reset,
   l2_line_responder_if.slave bus
);

   typedef enum logic [1:0] {StIdle, StWriteBack, StAllocate, StRespond} state_e;

   state_e                state_q;
   logic [127:0]          data_q  [NUM_OF_SET];
   logic [TAG_W-1:0]      tag_q   [NUM_OF_SET];
   logic [NUM_OF_SET-1:0] valid_q;
   logic [NUM_OF_SET-1:0] dirty_q;

   logic                  l1_ready_q;
   logic [127:0]          l1_rdata_q;
   logic                  mem_read_q;
   logic                  mem_write_q;
   logic [27:0]           mem_addr_q;
   logic [127:0]          mem_wdata_q;

   logic [SET_BITS-1:0]   idx;
   logic [TAG_W-1:0]      tag;
   logic                  req_rd;
   logic                  req_wr;
   logic                  hit;
   logic                  victim_dirty;
   logic                  unused_addr_bits;

   // Simultaneous read and write is illegal; read wins.
   always_comb begin
      idx          = bus.l1_addr[1+SET_BITS:2];
      tag          = bus.l1_addr[29:2+SET_BITS];
      req_rd       = bus.l1_read;
      req_wr       = bus.l1_write & ~bus.l1_read;
      hit          = valid_q[idx] && (tag_q[idx] == tag);
      victim_dirty = valid_q[idx] & dirty_q[idx];
   end

   assign unused_addr_bits = ^bus.l1_addr[1:0];

   always_ff @(posedge clk) begin
      if (proc_reset) begin
         state_q     <= StIdle;
         valid_q     <= '0;
         dirty_q     <= '0;
         l1_ready_q  <= 1'b0;
         l1_rdata_q  <= '0;
         mem_read_q  <= 1'b0;
         mem_write_q <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (req_rd || req_wr) begin
                  if (hit) begin
                     if (req_rd) begin
                        l1_rdata_q <= data_q[idx];
                     end else begin
                        data_q[idx]  <= bus.l1_wdata;
                        dirty_q[idx] <= 1'b1;
                     end
                     l1_ready_q <= 1'b1;
                     state_q    <= StRespond;
                  end else if (victim_dirty) begin
                     mem_write_q <= 1'b1;
                     mem_addr_q  <= {tag_q[idx], idx};
                     mem_wdata_q <= data_q[idx];
                     state_q     <= StWriteBack;
                  end else if (req_rd) begin
                     mem_read_q <= 1'b1;
                     mem_addr_q <= bus.l1_addr[29:2];
                     state_q    <= StAllocate;
                  end else begin
                     // Full-line write: install without fetching.
                     data_q[idx]  <= bus.l1_wdata;
                     tag_q[idx]   <= tag;
                     valid_q[idx] <= 1'b1;
                     dirty_q[idx] <= 1'b1;
                     l1_ready_q   <= 1'b1;
                     state_q      <= StRespond;
                  end
               end
            end
            StWriteBack: begin
               if (bus.mem_ready) begin
                  mem_write_q <= 1'b0;
                  if (req_rd) begin
                     dirty_q[idx] <= 1'b0;
                     mem_read_q   <= 1'b1;
                     mem_addr_q   <= bus.l1_addr[29:2];
                     state_q      <= StAllocate;
                  end else begin
                     data_q[idx]  <= bus.l1_wdata;
                     tag_q[idx]   <= tag;
                     valid_q[idx] <= 1'b1;
                     dirty_q[idx] <= 1'b1;
                     l1_ready_q   <= 1'b1;
                     state_q      <= StRespond;
                  end
               end
            end
            StAllocate: begin
               if (bus.mem_ready) begin
                  data_q[idx]  <= bus.mem_rdata;
                  tag_q[idx]   <= tag;
                  valid_q[idx] <= 1'b1;
                  dirty_q[idx] <= 1'b0;
                  l1_rdata_q   <= bus.mem_rdata;
                  mem_read_q   <= 1'b0;
                  l1_ready_q   <= 1'b1;
                  state_q      <= StRespond;
               end
            end
            StRespond: begin
               l1_ready_q <= 1'b0;
               state_q    <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign bus.l1_ready  = l1_ready_q;
   assign bus.l1_rdata  = l1_rdata_q;
   assign bus.mem_read  = mem_read_q;
   assign bus.mem_write = mem_write_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_l2_line_responder.sv
// Directed bench for l2_line_responder: L1 driver, memory responder model and
// scoreboards for L1 responses and expected memory transactions.
module tb_l2_line_responder;

   localparam int LAT = 3;
   localparam logic [127:0] JUNK   = {4{32'hDEADBEEF}};
   localparam logic [127:0] FILL_A = {16{8'hA5}};
   localparam logic [127:0] WR_1   = {16{8'h11}};
   localparam logic [127:0] WR_2   = {16{8'h22}};
   localparam logic [127:0] FILL_B = 128'h0123456789ABCDEF_FEDCBA9876543210;
   localparam logic [127:0] FILL_C = {4{32'hC0FFEE00}};
   localparam logic [127:0] FILL_D = {8{16'h5A3C}};
   localparam logic [127:0] FILL_E = {2{64'h0F1E2D3C4B5A6978}};

   typedef struct packed {
      logic         wr;
      logic [27:0]  addr;
      logic [127:0] data;
   } mem_t;

   logic clk = 1'b0;
   logic proc_reset;

   l2_line_responder_if bus ();

   l2_line_responder dut (
      .clk        (clk),
      .proc_reset (proc_reset),
      .bus        (bus)
   );

   always #5 clk = ~clk;

   int            checks = 0;
   int            errors = 0;
   logic [127:0]  l1_q[$];
   mem_t          mem_q[$];
   logic [127:0]  last_rd = '0;

   logic          busy = 1'b0;
   int            cnt;
   logic          cur_wr;
   logic [27:0]   cur_addr;
   logic [127:0]  cur_fill;
   mem_t          e;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual %0h required %0h", name, act, exp);
      end
   endtask

   task automatic check_zero(input string name);
      chk({name, " l1_ready"},  {127'd0, bus.l1_ready},  '0);
      chk({name, " l1_rdata"},  bus.l1_rdata,            '0);
      chk({name, " mem_read"},  {127'd0, bus.mem_read},  '0);
      chk({name, " mem_write"}, {127'd0, bus.mem_write}, '0);
      chk({name, " mem_addr"},  {100'd0, bus.mem_addr},  '0);
      chk({name, " mem_wdata"}, bus.mem_wdata,           '0);
   endtask

   // Issue one request from a negedge; on return the request has been held
   // through RESPOND and is dropped unless the caller chains another one.
   task automatic req(input logic rd, input logic [29:0] addr, input logic [127:0] wdata,
                      input logic [127:0] rdat, input int exp_lat, input logic chain,
                      input string name);
      int n = 0;
      if (rd) last_rd = rdat;
      l1_q.push_back(last_rd);
      bus.l1_read  = rd;
      bus.l1_write = !rd;
      bus.l1_addr  = addr;
      bus.l1_wdata = wdata;
      do begin
         @(negedge clk);
         n++;
      end while (!bus.l1_ready && n < 200);
      chk({name, " latency"}, 128'(n), 128'(exp_lat));
      @(negedge clk);
      if (!chain) begin
         bus.l1_read  = 1'b0;
         bus.l1_write = 1'b0;
      end
   endtask

   // L1 response monitor.
   initial begin
      forever begin
         @(negedge clk);
         if (bus.l1_ready) begin
            if (l1_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL l1 unexpected ready actual 1 required 0");
            end else begin
               chk("l1_rdata", bus.l1_rdata, l1_q.pop_front());
            end
         end
      end
   end

   // Memory responder and transaction checker.
   initial begin
      bus.mem_ready = 1'b0;
      bus.mem_rdata = JUNK;
      forever begin
         @(negedge clk);
         if (bus.mem_ready) begin
            bus.mem_ready = 1'b0;
            bus.mem_rdata = JUNK;
            busy          = 1'b0;
            chk("mem req drop", {127'd0, cur_wr ? bus.mem_write : bus.mem_read}, '0);
         end else if (busy) begin
            if (!(cur_wr ? bus.mem_write : bus.mem_read)) begin
               busy = 1'b0;
            end else begin
               chk("mem addr stable", {100'd0, bus.mem_addr}, {100'd0, cur_addr});
               cnt++;
               if (cnt == LAT - 1) begin
                  bus.mem_ready = 1'b1;
                  bus.mem_rdata = cur_fill;
               end
            end
         end
         if (!busy && !bus.mem_ready && (bus.mem_read || bus.mem_write)) begin
            chk("mem rd/wr exclusive", {127'd0, bus.mem_read & bus.mem_write}, '0);
            if (mem_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL mem unexpected traffic actual addr %0h required none", bus.mem_addr);
            end else begin
               e = mem_q.pop_front();
               chk("mem kind", {127'd0, bus.mem_write}, {127'd0, e.wr});
               chk("mem addr", {100'd0, bus.mem_addr}, {100'd0, e.addr});
               if (e.wr) chk("mem wdata", bus.mem_wdata, e.data);
            end
            busy     = 1'b1;
            cnt      = 0;
            cur_wr   = bus.mem_write;
            cur_addr = bus.mem_addr;
            cur_fill = e.data;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout actual running required finished");
      $fatal(1, "timeout");
   end

   initial begin
      int n;
      proc_reset   = 1'b1;
      bus.l1_read  = 1'b0;
      bus.l1_write = 1'b0;
      bus.l1_addr  = '0;
      bus.l1_wdata = '0;
      repeat (3) @(negedge clk);
      check_zero("reset");
      proc_reset = 1'b0;
      @(negedge clk);

      mem_q.push_back('{wr: 1'b0, addr: 28'h4, data: FILL_A});
      req(1'b1, 30'h10, '0, FILL_A, LAT + 1, 1'b0, "cold read miss");
      req(1'b1, 30'h10, '0, FILL_A, 1, 1'b0, "read hit");
      req(1'b0, 30'h10, WR_1, '0, 1, 1'b0, "write hit");

      mem_q.push_back('{wr: 1'b1, addr: 28'h4, data: WR_1});
      mem_q.push_back('{wr: 1'b0, addr: 28'hC, data: FILL_B});
      req(1'b1, 30'h30, '0, FILL_B, 2 * LAT + 1, 1'b0, "dirty eviction");

      req(1'b0, 30'h14, WR_2, '0, 1, 1'b0, "write miss clean");
      req(1'b1, 30'h14, '0, WR_2, 1, 1'b0, "read after write miss");

      req(1'b1, 30'h30, '0, FILL_B, 1, 1'b1, "b2b hit 0");
      req(1'b1, 30'h14, '0, WR_2, 1, 1'b1, "b2b hit 1");
      mem_q.push_back('{wr: 1'b0, addr: 28'h14, data: FILL_C});
      req(1'b1, 30'h50, '0, FILL_C, LAT + 1, 1'b0, "b2b miss");

      // Abort a fill with reset.
      mem_q.push_back('{wr: 1'b0, addr: 28'h10, data: FILL_D});
      bus.l1_read = 1'b1;
      bus.l1_addr = 30'h40;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!bus.mem_read && n < 50);
      chk("fill started", {127'd0, bus.mem_read}, 128'd1);
      proc_reset  = 1'b1;
      bus.l1_read = 1'b0;
      @(negedge clk);
      check_zero("reset mid-fill");
      proc_reset = 1'b0;
      last_rd    = '0;
      @(negedge clk);

      mem_q.push_back('{wr: 1'b0, addr: 28'h10, data: FILL_D});
      req(1'b1, 30'h40, '0, FILL_D, LAT + 1, 1'b0, "refill after reset");
      mem_q.push_back('{wr: 1'b0, addr: 28'h5, data: FILL_E});
      req(1'b1, 30'h14, '0, FILL_E, LAT + 1, 1'b0, "invalid after reset");

      repeat (5) @(negedge clk);
      chk("l1 queue drained", 128'(l1_q.size()), '0);
      chk("mem queue drained", 128'(mem_q.size()), '0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
